vga_pixel_fetch: RTL and testbench

Pixel fetch stage between the VGA timing generator and the graphic generator, running in the VGA pixel clock domain. It turns the raster position (x, y) into framebuffer read addresses for a 400×200 image window and issues one read per in-window pixel. It realigns returned data with the raster and presents it as `pixel` plus a valid flag. It supports two address maps: a linear map and a split map that reads the lower half of the image from a second memory bank.

---
 rtl/vga_pixel_fetch.sv | 195 +++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch: turns raster (x, y) into framebuffer reads and realigns returned data with the raster.
// Optional split address map (lower half from a second bank) is built when PIXEL_FETCH_SPLIT_EN is defined.
module vga_pixel_fetch #(
    parameter int          IMG_W      = 400,
    parameter int          IMG_H      = 200,
    parameter int          SPLIT_BASE = 80000,
    parameter int          RD_LAT     = 2,
    parameter logic [31:0] BG_PIXEL   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        mode_sel,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pixel,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [16:0] LP_LAST = 17'(IMG_W * IMG_H - 1);
    localparam logic [16:0] LP_HALF = 17'(IMG_W * IMG_H / 2);
    localparam logic [10:0] LP_W    = 11'(IMG_W);
    localparam logic [10:0] LP_H    = 11'(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [16:0] r_cnt;
    logic [16:0] w_cnt_nx;
    logic [16:0] w_idx;
    logic        w_in_win;
    logic        w_frame_start;
    logic        w_issue;
    logic        w_done_nx;
    logic        w_ovr_set;
    logic [31:0] w_addr;

    logic [31:0]       r_mem_addr;
    logic              r_mem_rd;
    logic              r_frame_done;
    logic              r_overrun;
    logic [RD_LAT-1:0] r_vpipe;
    logic [31:0]       r_pixel;
    logic              r_pixel_valid;

    assign w_in_win      = ({1'b0, x} < LP_W) && ({1'b0, y} < LP_H);
    assign w_frame_start = (x == 10'd0) && (y == 10'd0);

`ifdef PIXEL_FETCH_SPLIT_EN
    logic        r_mode_q;
    logic        w_mode_eff;
    logic [16:0] w_hi_off;

    // Map select is captured only at frame start so a frame never changes map midway
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_q <= 1'b0;
        end else if (w_frame_start) begin
            r_mode_q <= mode_sel;
        end
    end

    assign w_mode_eff = w_frame_start ? mode_sel : r_mode_q;
    assign w_hi_off   = w_idx - LP_HALF;

    // Split map: upper half linear, lower half relocated to SPLIT_BASE
    always_comb begin
        w_addr = {15'd0, w_idx};
        if (w_mode_eff && (w_idx >= LP_HALF)) begin
            w_addr = 32'(SPLIT_BASE) + {15'd0, w_hi_off};
        end else begin
            w_addr = {15'd0, w_idx};
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode_sel;
    assign w_addr        = {15'd0, w_idx};
`endif

    // Next-state, issue and counter decisions
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx      = r_cnt;
        w_issue    = 1'b0;
        w_done_nx  = 1'b0;
        w_ovr_set  = 1'b0;
        if (w_frame_start) begin
            // (0,0) restarts the count from any state and is itself issued
            w_issue    = 1'b1;
            w_idx      = 17'd0;
            w_cnt_nx   = 17'd1;
            if (LP_LAST == 17'd0) begin
                w_done_nx  = 1'b1;
                w_state_nx = S_DONE;
            end else begin
                w_state_nx = S_FETCH;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_IDLE;
                end
                S_FETCH: begin
                    if (w_in_win) begin
                        w_issue  = 1'b1;
                        w_cnt_nx = r_cnt + 17'd1;
                        if (r_cnt == LP_LAST) begin
                            w_done_nx  = 1'b1;
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_FETCH;
                        end
                    end else begin
                        w_state_nx = S_FETCH;
                    end
                end
                S_DONE: begin
                    if (w_in_win) begin
                        w_ovr_set = 1'b1;
                    end else begin
                        w_ovr_set = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered issue-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 17'd0;
            r_mem_addr   <= 32'd0;
            r_mem_rd     <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_mem_rd     <= w_issue;
            r_frame_done <= w_done_nx;
            if (w_issue) begin
                r_mem_addr <= w_addr;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Read strobe delayed to line up with returning memory data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= r_mem_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // Return-side pixel register; background when no read lands this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pixel       <= BG_PIXEL;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= r_vpipe[RD_LAT-1];
            r_pixel       <= r_vpipe[RD_LAT-1] ? mem_rdata : BG_PIXEL;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign pixel       = r_pixel;
    assign pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a small 8x4 window: raster scenarios from a table, memory returns data = address.
module tb_vga_pixel_fetch;

    localparam int          W     = 8;
    localparam int          H     = 4;
    localparam int          TOTAL = W * H;
    localparam int          HALF  = TOTAL / 2;
    localparam int          SB    = 100;
    localparam int          LAT   = 3;
    localparam logic [31:0] BG    = 32'hBB00_00BB;
    localparam int          RX    = 12;
    localparam int          RY    = 6;
`ifdef PIXEL_FETCH_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = 10'(RX);
    logic [9:0]  y = 10'(RY);
    logic        mode_sel = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] pixel;
    logic        pixel_valid;
    logic        frame_done;
    logic        overrun;

    vga_pixel_fetch #(
        .IMG_W(W), .IMG_H(H), .SPLIT_BASE(SB), .RD_LAT(LAT), .BG_PIXEL(BG)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .mode_sel(mode_sel),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .pixel(pixel), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic        fd;
        logic        ov;
    } iss_t;
    typedef struct packed {
        logic        v;
        logic [31:0] px;
    } pix_t;
    typedef struct {
        int frames;
        bit ms;
        int tog_y;
        int rst_at;
        bit inj;
        int e_rd;
        int e_last;
        bit e_ov;
    } scn_t;

    iss_t q_iss[$];
    pix_t q_pix[$];
    logic        mq_rd   [0:LAT];
    logic [31:0] mq_addr [0:LAT];

    int          errors = 0;
    int          checks = 0;
    int          m_st, m_cnt;
    bit          m_mode, m_ov;
    logic [31:0] m_last;
    int          obs_rd;
    logic [31:0] obs_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] emap(input int i, input bit m);
        if (SPLIT_ON && m && i >= HALF) return 32'(SB + i - HALF);
        return 32'(i);
    endfunction

    task automatic model_push(input int xi, input int yi, input bit ms);
        iss_t e;
        pix_t p;
        bit   fs, inw;
        int   idx;
        fs = (xi == 0) && (yi == 0);
        inw = (xi < W) && (yi < H);
        e = '0;
        idx = 0;
        if (fs) begin
            if (SPLIT_ON) m_mode = ms;
            e.rd = 1'b1; m_cnt = 1; m_st = 1;
        end else if (m_st == 1 && inw) begin
            idx = m_cnt; e.rd = 1'b1; m_cnt++;
            if (idx == TOTAL - 1) begin e.fd = 1'b1; m_st = 2; end
        end else if (m_st == 2 && inw) begin
            m_ov = 1'b1;
        end
        if (e.rd) m_last = emap(idx, m_mode);
        e.addr = m_last;
        e.ov = m_ov;
        q_iss.push_back(e);
        p.v = e.rd;
        p.px = e.rd ? m_last : BG;
        q_pix.push_back(p);
    endtask

    task automatic reset_checks();
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_pixel", pixel, BG);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        x = 10'(RX);
        y = 10'(RY);
        #1;
        q_iss.delete();
        q_pix.delete();
        for (int i = 0; i <= LAT; i++) begin mq_rd[i] = 1'b0; mq_addr[i] = 32'd0; end
        m_st = 0; m_cnt = 0; m_mode = 1'b0; m_ov = 1'b0; m_last = 32'd0;
        obs_rd = 0;
        reset_checks();
        @(posedge clk);
        #1;
        reset_checks();
        rst = 1'b1;
    endtask

    task automatic cycle(input int xi, input int yi, input bit ms);
        iss_t e;
        pix_t p;
        @(posedge clk);
        #1;
        if (q_iss.size() == 1) begin
            e = q_iss.pop_front();
            check("mem_rd", 32'(mem_rd), 32'(e.rd));
            check("mem_addr", mem_addr, e.addr);
            check("frame_done", 32'(frame_done), 32'(e.fd));
            check("overrun", 32'(overrun), 32'(e.ov));
        end
        if (q_pix.size() == LAT + 2) begin
            p = q_pix.pop_front();
            check("pixel_valid", 32'(pixel_valid), 32'(p.v));
            check("pixel", pixel, p.px);
        end
        if (mem_rd) begin obs_rd++; obs_last = mem_addr; end
        for (int i = LAT; i > 0; i--) begin mq_rd[i] = mq_rd[i-1]; mq_addr[i] = mq_addr[i-1]; end
        mq_rd[0] = mem_rd;
        mq_addr[0] = mem_addr;
        mem_rdata = mq_rd[LAT] ? mq_addr[LAT] : 32'hDEAD_BEEF;
        x = 10'(xi);
        y = 10'(yi);
        mode_sel = ms;
        model_push(xi, yi, ms);
    endtask

    initial begin
        scn_t tbl[6];
        int   last_split;
        bit   cur;
        int   n;
        last_split = SPLIT_ON ? (SB + HALF - 1) : (TOTAL - 1);
        //        frames ms tog_y rst_at inj  e_rd       e_last      e_ov
        tbl[0] = '{2, 1'b0, -1, -1, 1'b0, 2 * TOTAL, TOTAL - 1,  1'b0};
        tbl[1] = '{1, 1'b1, -1, -1, 1'b0, TOTAL,     last_split, 1'b0};
        tbl[2] = '{2, 1'b0,  2, -1, 1'b0, 2 * TOTAL, last_split, 1'b0};
        tbl[3] = '{2, 1'b0, -1, 20, 1'b0, TOTAL,     TOTAL - 1,  1'b0};
        tbl[4] = '{1, 1'b0, -1, -1, 1'b1, TOTAL,     TOTAL - 1,  1'b1};
        tbl[5] = '{1, 1'b1, -1, -1, 1'b0, TOTAL,     last_split, 1'b1};

        #2;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            obs_rd = 0;
            obs_last = 32'hFFFF_FFFF;
            cur = tbl[s].ms;
            n = 0;
            for (int f = 0; f < tbl[s].frames; f++) begin
                for (int yy = 0; yy < RY; yy++) begin
                    for (int xx = 0; xx < RX; xx++) begin
                        if (f == 0 && yy == tbl[s].tog_y && xx == 0) cur = ~cur;
                        cycle(xx, yy, cur);
                        n++;
                        if (n == tbl[s].rst_at) do_reset();
                    end
                end
            end
            if (tbl[s].inj) begin
                for (int xx = 0; xx < RX; xx++) cycle(xx, 1, cur);
            end
            for (int k = 0; k < LAT + 3; k++) cycle(RX, RY, cur);
            check($sformatf("scn%0d_rd_count", s), 32'(obs_rd), 32'(tbl[s].e_rd));
            check($sformatf("scn%0d_last_addr", s), obs_last, 32'(tbl[s].e_last));
            check($sformatf("scn%0d_overrun", s), 32'(overrun), 32'(tbl[s].e_ov));
        end
        do_reset();
        for (int k = 0; k < 4; k++) cycle(RX, RY, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
